// File: rtl/riscv_pkg.sv
// RV32I encoding constants shared by the decoder and the instruction encoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0010;
  localparam logic [3:0] ALUC_OR   = 4'b0011;
  localparam logic [3:0] ALUC_XOR  = 4'b0100;
  localparam logic [3:0] ALUC_SLL  = 4'b0101;
  localparam logic [3:0] ALUC_SLT  = 4'b0110;
  localparam logic [3:0] ALUC_SLTU = 4'b0111;
  localparam logic [3:0] ALUC_SRL  = 4'b1000;
  localparam logic [3:0] ALUC_SRA  = 4'b1001;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {CLS_OP, CLS_IMM, CLS_LOAD, CLS_STORE} inst_class_e;
  typedef enum logic [1:0] {ENC_IDLE, ENC_RUN, ENC_FLUSH} enc_state_e;

  function automatic logic [2:0] alu_f3(input logic [3:0] aluc);
    case (aluc)
      ALUC_SLL:           return F3_SLL;
      ALUC_SLT:           return F3_SLT;
      ALUC_SLTU:          return F3_SLTU;
      ALUC_XOR:           return F3_XOR;
      ALUC_SRL, ALUC_SRA: return F3_SRL_SRA;
      ALUC_OR:            return F3_OR;
      ALUC_AND:           return F3_AND;
      default:            return F3_ADD_SUB;
    endcase
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: decoded micro-op fields -> RV32I word plus illegal flag.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  aluc,
  input  logic        aluOut_WB_memOut,
  input  logic        write_mem,
  input  logic        rs2Data_EX_imm32,
  input  logic        write_reg,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm_12,
  output logic [31:0] word,
  output logic        illegal
);

  inst_class_e cls;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;

  always_comb begin
    cls = CLS_OP;
    if (write_mem)             cls = CLS_STORE;
    else if (aluOut_WB_memOut) cls = CLS_LOAD;
    else if (rs2Data_EX_imm32) cls = CLS_IMM;
  end

  assign f3       = alu_f3(aluc);
  assign f7       = (aluc == ALUC_SUB || aluc == ALUC_SRA) ? F7_ALT : F7_BASE;
  assign is_shift = (aluc == ALUC_SLL) || (aluc == ALUC_SRL) || (aluc == ALUC_SRA);

  always_comb begin
    word = '0;
    case (cls)
      CLS_LOAD:  word = {imm_12, rs1, F3_WORD, rd, OPC_LOAD};
      CLS_STORE: word = {imm_12[11:5], rs2, rs1, F3_WORD, imm_12[4:0], OPC_STORE};
      CLS_IMM: begin
        // Shift immediates carry only a 5-bit shamt; the top bits become funct7.
        if (is_shift) word = {f7, imm_12[4:0], rs1, f3, rd, OPC_IMM};
        else          word = {imm_12, rs1, f3, rd, OPC_IMM};
      end
      default:   word = {f7, rs2, rs1, f3, rd, OPC_OP};
    endcase
  end

  assign illegal = (aluc > ALUC_SRA)
                 || (cls == CLS_IMM && aluc == ALUC_SUB)
                 || ((cls == CLS_LOAD || cls == CLS_STORE) && aluc != ALUC_ADD)
                 || (write_mem && write_reg)
                 || (cls != CLS_STORE && !write_reg);

endmodule

// File: rtl/inst_encoder.sv
// Streams packed RV32I words into IMEM through a small FIFO with a run/flush FSM.
// Optional: define ILLEGAL_AS_NOP_EN to replace illegal micro-ops with addi x0,x0,0.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        aluc,
  input  logic              aluOut_WB_memOut,
  input  logic              write_mem,
  input  logic              rs2Data_EX_imm32,
  input  logic              write_reg,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [11:0]       imm_12,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  enc_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       packed_word, push_word;
  logic              illegal, accept, push, pop;

  inst_pack u_pack (
    .aluc             (aluc),
    .aluOut_WB_memOut (aluOut_WB_memOut),
    .write_mem        (write_mem),
    .rs2Data_EX_imm32 (rs2Data_EX_imm32),
    .write_reg        (write_reg),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm_12           (imm_12),
    .word             (packed_word),
    .illegal          (illegal)
  );

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready   = (state == ENC_RUN) && (fifo_count < FULL_CNT);
  assign accept     = in_valid && in_ready;
  assign imem_we    = (fifo_count != '0);
  assign pop        = imem_we && imem_ready;
  assign imem_addr  = addr;
  assign imem_wdata = fifo_mem[rd_ptr];
  assign busy       = (state != ENC_IDLE);
  assign done       = (state == ENC_FLUSH) && (fifo_count == '0);

`ifdef ILLEGAL_AS_NOP_EN
  assign push      = accept;
  assign push_word = illegal ? NOP_WORD : packed_word;
`else
  assign push      = accept && !illegal;
  assign push_word = packed_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The FIFO is always empty in IDLE, so a start load never collides with a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENC_IDLE;
      addr     <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (pop) begin
        addr     <= addr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (accept && illegal) err <= 1'b1;
      case (state)
        ENC_IDLE: if (start) begin
          state    <= ENC_RUN;
          addr     <= base_addr;
          word_cnt <= '0;
          err      <= 1'b0;
        end
        ENC_RUN:   if (finish) state <= ENC_FLUSH;
        ENC_FLUSH: if (fifo_count == '0) state <= ENC_IDLE;
        default:   state <= ENC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (honours ILLEGAL_AS_NOP_EN if defined).
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  aluc = '0;
  logic        aluOut_WB_memOut = 1'b0;
  logic        write_mem = 1'b0;
  logic        rs2Data_EX_imm32 = 1'b0;
  logic        write_reg = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [11:0] imm_12 = '0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready = 1'b1;
  logic        busy, done, err;
  logic [9:0]  word_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(10), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .aluc(aluc),
    .aluOut_WB_memOut(aluOut_WB_memOut), .write_mem(write_mem),
    .rs2Data_EX_imm32(rs2Data_EX_imm32), .write_reg(write_reg),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm_12(imm_12),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  task automatic set_uop(input logic [3:0] a, input logic wm, input logic ld,
                         input logic im, input logic wr, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] imm);
    aluc = a; write_mem = wm; aluOut_WB_memOut = ld; rs2Data_EX_imm32 = im;
    write_reg = wr; rd = d; rs1 = s1; rs2 = s2; imm_12 = imm;
  endtask

  // Presents one micro-op and holds it until the handshake edge has passed.
  task automatic push_uop(input logic [3:0] a, input logic wm, input logic ld,
                          input logic im, input logic wr, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] imm);
    int waited = 0;
    set_uop(a, wm, ld, im, wr, d, s1, s2, imm);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic go_idle();
    int waited = 0;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, word_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h cnt=%h required all 0",
               in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, word_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_start_addi();
    do_start(10'h010);
    @(negedge clk);
    total++;
    if ({busy, in_ready} !== 2'b11) begin
      bad++; $display("FAIL start_run: busy/rdy=%b%b required 11", busy, in_ready);
    end
    push_uop(4'b0000, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, 12'h005);
    @(negedge clk);
    total++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'h010, 32'h00500093}) begin
      bad++; $display("FAIL addi_write: we=%b addr=%h wdata=%h required 1 010 00500093", imem_we, imem_addr, imem_wdata);
    end
    go_idle();
  endtask

  task automatic test_store_sub();
    do_start(10'h010);
    push_uop(4'b0000, 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 12'h008);
    @(negedge clk);
    total++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'h010, 32'h0020A423}) begin
      bad++; $display("FAIL store_write: we=%b addr=%h wdata=%h required 1 010 0020a423", imem_we, imem_addr, imem_wdata);
    end
    push_uop(4'b0001, 0, 0, 0, 1, 5'd3, 5'd1, 5'd2, 12'h000);
    @(negedge clk);
    total++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'h011, 32'h402081B3}) begin
      bad++; $display("FAIL sub_write: we=%b addr=%h wdata=%h required 1 011 402081b3", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++;
    if ({imem_we, word_cnt} !== {1'b0, 10'd2}) begin
      bad++; $display("FAIL store_sub_cnt: we=%b cnt=%0d required 0 2", imem_we, word_cnt);
    end
  endtask

  task automatic test_shift_load();
    push_uop(4'b1001, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 12'hFE3);
    @(negedge clk);
    total++;
    if ({imem_addr, imem_wdata} !== {10'h012, 32'h4032D293}) begin
      bad++; $display("FAIL srai_write: addr=%h wdata=%h required 012 4032d293", imem_addr, imem_wdata);
    end
    push_uop(4'b0000, 0, 1, 1, 1, 5'd4, 5'd2, 5'd0, 12'hFFC);
    @(negedge clk);
    total++;
    if ({imem_addr, imem_wdata} !== {10'h013, 32'hFFC12203}) begin
      bad++; $display("FAIL load_write: addr=%h wdata=%h required 013 ffc12203", imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++;
    if (word_cnt !== 10'd4) begin
      bad++; $display("FAIL shift_load_cnt: cnt=%0d required 4", word_cnt);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    imem_ready = 1'b0;
    set_uop(4'b0000, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, 12'h001);
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready0: rdy=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    set_uop(4'b0000, 0, 0, 1, 1, 5'd2, 5'd0, 5'd0, 12'h002);
    @(negedge clk);
    total++;
    if ({in_ready, imem_we, imem_wdata} !== {1'b1, 1'b1, 32'h00100093}) begin
      bad++; $display("FAIL bp_ready1: rdy=%b we=%b wdata=%h required 1 1 00100093", in_ready, imem_we, imem_wdata);
    end
    @(posedge clk); #1;
    set_uop(4'b0000, 0, 0, 1, 1, 5'd3, 5'd0, 5'd0, 12'h003);
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, imem_addr, imem_wdata} !== {1'b0, 10'h014, 32'h00100093}) begin
      bad++; $display("FAIL bp_hold: rdy=%b addr=%h wdata=%h required 0 014 00100093", in_ready, imem_addr, imem_wdata);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, imem_addr, imem_wdata} !== {1'b1, 10'h015, 32'h00200113}) begin
      bad++; $display("FAIL bp_drain1: rdy=%b addr=%h wdata=%h required 1 015 00200113", in_ready, imem_addr, imem_wdata);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_addr, imem_wdata} !== {10'h016, 32'h00300193}) begin
      bad++; $display("FAIL bp_drain2: addr=%h wdata=%h required 016 00300193", imem_addr, imem_wdata);
    end
    @(negedge clk);
    total++;
    if ({imem_we, word_cnt} !== {1'b0, 10'd7}) begin
      bad++; $display("FAIL bp_cnt: we=%b cnt=%0d required 0 7", imem_we, word_cnt);
    end
  endtask

  task automatic test_illegal();
    push_uop(4'b1010, 0, 0, 1, 1, 5'd1, 5'd1, 5'd0, 12'h000);
    @(negedge clk);
`ifdef ILLEGAL_AS_NOP_EN
    total++;
    if ({err, imem_we, imem_wdata} !== {1'b1, 1'b1, 32'h00000013}) begin
      bad++; $display("FAIL illegal_nop: err=%b we=%b wdata=%h required 1 1 00000013", err, imem_we, imem_wdata);
    end
`else
    total++;
    if ({err, imem_we, word_cnt} !== {1'b1, 1'b0, 10'd7}) begin
      bad++; $display("FAIL illegal_drop: err=%b we=%b cnt=%0d required 1 0 7", err, imem_we, word_cnt);
    end
`endif
    go_idle();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_sticky: err=%b required 1", err);
    end
    @(posedge clk); #1;
    do_start(10'h020);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_clear: err=%b required 0", err);
    end
    push_uop(4'b0001, 0, 0, 1, 1, 5'd1, 5'd1, 5'd0, 12'h001);
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL subi_illegal: err=%b required 1", err);
    end
    go_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_flush();
    do_start(10'h3FF);
    push_uop(4'b0000, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, 12'h001);
    @(negedge clk);
    total++;
    if ({imem_addr, imem_wdata} !== {10'h3FF, 32'h00100093}) begin
      bad++; $display("FAIL wrap_first: addr=%h wdata=%h required 3ff 00100093", imem_addr, imem_wdata);
    end
    push_uop(4'b0000, 0, 0, 1, 1, 5'd2, 5'd0, 5'd0, 12'h002);
    @(negedge clk);
    total++;
    if ({imem_addr, imem_wdata} !== {10'h000, 32'h00200113}) begin
      bad++; $display("FAIL wrap_second: addr=%h wdata=%h required 000 00200113", imem_addr, imem_wdata);
    end
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    total++;
    if ({done, busy, imem_we, word_cnt} !== {1'b1, 1'b1, 1'b0, 10'd2}) begin
      bad++; $display("FAIL flush_done: done=%b busy=%b we=%b cnt=%0d required 1 1 0 2", done, busy, imem_we, word_cnt);
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_flush();
    do_start(10'h005);
    imem_ready = 1'b0;
    push_uop(4'b0000, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, 12'h001);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, in_ready, imem_we, done} !== 4'b1010) begin
      bad++; $display("FAIL flush_stall: busy=%b rdy=%b we=%b done=%b required 1 0 1 0", busy, in_ready, imem_we, done);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, word_cnt} !== '0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h cnt=%h required all 0",
               in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_addi();
    @(posedge clk); #1;
    test_store_sub();
    test_shift_load();
    test_backpressure();
    test_illegal();
    test_wrap_flush();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the RV32I decode stage: accepts decoded micro-op fields in the same form the decoder produces (aluc, control flags, rd/rs1/rs2, imm_12).
- Re-packs each micro-op into a 32-bit RV32I instruction word and streams the words into instruction memory at consecutive word addresses.
- Used by the test and boot infrastructure to load programs into IMEM.
- Contains a valid/ready input, a 2-entry output FIFO with an IMEM ready backpressure port, an address counter and a run/flush state machine.

Parameters:
- ADDR_W, 10, IMEM word-address width; also the width of word_cnt.
- FIFO_DEPTH, 2, output buffer entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; in IDLE, loads base_addr and enters RUN.
- base_addr  in  ADDR_W  first IMEM word address.
- finish  in  1  pulse; in RUN, stops intake and drains the FIFO.
- in_valid  in  1  micro-op valid.
- in_ready  out  1  micro-op accepted when in_valid && in_ready.
- aluc  in  4  ALU code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 slt, 0111 sltu, 1000 srl, 1001 sra.
- aluOut_WB_memOut  in  1  load flag.
- write_mem  in  1  store flag.
- rs2Data_EX_imm32  in  1  immediate operand flag.
- write_reg  in  1  register writeback flag.
- rd, rs1, rs2  in  5 each  register indices.
- imm_12  in  12  immediate; for shifts only [4:0] is used.
- imem_we  out  1  IMEM write strobe; valid when the FIFO is non-empty.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  IMEM accepts the write when imem_we && imem_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the flush completes.
- err  out  1  sticky illegal-micro-op flag; cleared by start.
- word_cnt  out  ADDR_W  number of words written since start; wraps.

Behaviour:
- Reset values: state IDLE; FIFO empty; in_ready, imem_we, busy, done and err are 0; imem_addr, imem_wdata and word_cnt are 0. Reset mid-operation discards FIFO contents, and the partial write in that cycle does not happen.

State machine:
- IDLE: in_ready=0. start → RUN; addr ← base_addr; word_cnt ← 0; err ← 0. finish is ignored.
- RUN: in_ready = (fifo_count < FIFO_DEPTH). This value is registered-state based and does not depend on a same-cycle pop. finish → FLUSH. A beat accepted in the same cycle as finish is kept. start is ignored.
- FLUSH: in_ready=0. When the FIFO is empty → IDLE, with done=1 for exactly that transition cycle. If the FIFO is already empty when finish arrives, the FSM still passes through FLUSH for one cycle.

Class selection (priority order):
- write_mem=1 → STORE.
- aluOut_WB_memOut=1 → LOAD.
- rs2Data_EX_imm32=1 → OP-IMM.
- otherwise → OP.

Encoding (func3 derived from aluc):
- LOAD: {imm_12, rs1, 010, rd, 0000011}.
- STORE: {imm_12[11:5], rs2, rs1, 010, imm_12[4:0], 0100011}.
- OP-IMM: {imm_12, rs1, f3, rd, 0010011}. For sll, srl and sra the upper 7 bits are forced to 0000000, or 0100000 for sra, followed by imm_12[4:0].
- OP: {f7, rs2, rs1, f3, rd, 0110011}. f7 = 0100000 for sub and sra, 0000000 otherwise.

Illegal micro-ops:
- aluc > 1001.
- sub with OP-IMM.
- LOAD or STORE with aluc != 0000.
- write_mem && write_reg both set.
- non-STORE with write_reg=0.
- An illegal micro-op is handshaken (consumed), sets err, and is not pushed to the FIFO.

Datapath timing:
- Encoding is combinational at accept and the word is pushed into the FIFO at that edge. Earliest imem_we is the next cycle (1-cycle latency).
- Pop on imem_we && imem_ready; on pop, addr and word_cnt increment.
- addr wraps modulo 2^ADDR_W with no error.
- Simultaneous push and pop is allowed at any occupancy below full.
- imem_wdata and imem_addr hold stable while imem_we=1 and imem_ready=0.

Optional Feature:
- Macro: ILLEGAL_AS_NOP_EN.
- Defined: each illegal micro-op pushes 0x00000013 (addi x0,x0,0) instead of being dropped; err is still set.
- Undefined: each illegal micro-op is dropped, as described under Behaviour.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: OPC_LOAD 0000011, OPC_STORE 0100011, OPC_IMM 0010011, OPC_OP 0110011;
  - func3 constants;
  - ALUC_* codes, shared with the decoder.
- One combinational sub-module, inst_pack: takes the fields and returns {word, illegal}.
- FIFO, FSM and counters stay in inst_encoder.

Test Plan:
- start with base_addr=0x010, then addi x1,x0,5 (aluc 0000, imm flag) → one cycle later imem_we=1, addr 0x010, wdata 0x00500093.
- Store x2 to 8(x1) then sub x3,x1,x2 → words 0x0020A423 at 0x010 and 0x402081B3 at 0x011; word_cnt=2.
- srai x5,x5,3 with imm_12=0xFE3 → 0x4032D293 (upper immediate bits ignored). Load x4 from -4(x2) with imm_12=0xFFC → 0xFFC12203.
- Hold imem_ready=0 and send 3 valid beats → in_ready falls after 2 accepts; wdata and addr stay stable. Release imem_ready → both words drain in order.
- Illegal aluc=1010 → err=1, no IMEM write (or 0x00000013 with ILLEGAL_AS_NOP_EN). A following start clears err.
- base_addr=all-ones, then 2 words → addresses all-ones then 0. finish → FLUSH, done is one pulse after the last write. Asserting rst during FLUSH returns all outputs to 0 asynchronously.
